mag_cmp_seq: RTL and testbench

//   Multi-cycle magnitude comparator for WIDTH-bit operands, signed or unsigned.

---
 rtl/mag_cmp_seq.sv | 162 ++++++++++++++++
 tb/tb_mag_cmp_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_cmp_seq.sv
// -----------------------------------------------------------------------------
// mag_cmp_seq
//   Multi-cycle magnitude comparator for WIDTH-bit operands, signed or unsigned.
//   A single 4-bit nibble comparator is walked from the MSB nibble down to the
//   LSB nibble. The walk stops at the first unequal nibble, so the result
//   latency depends on where the operands first differ.
//
//   Signed compares map both operands to offset-binary form by inverting
//   their sign bits when they are latched. After that mapping, an unsigned
//   nibble walk gives the correct two's-complement ordering.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      operands valid
//   in_ready   out  1      block idle, can accept operands
//   a_in       in   WIDTH  operand A
//   b_in       in   WIDTH  operand B
//   signed_in  in   1      1: two's-complement compare, 0: unsigned compare
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   aeqb       out  1      A == B
//   agtb       out  1      A > B
//   altb       out  1      A < B
//   cycles     out  CW     number of nibbles compared for this result (1..NIB)
// -----------------------------------------------------------------------------
module mag_cmp_seq #(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / 4,
    localparam int CW    = $clog2(NIB) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             signed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb,
    output logic [CW-1:0]    cycles
);

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
        $error("mag_cmp_seq: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sign_mask;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic             nib_ne;
    logic             nib_gt;
    logic             accept;

    // Only the sign bit is flipped for signed compares.
    assign sign_mask = {signed_in, {(WIDTH-1){1'b0}}};

    // The operand registers shift left by one nibble per CMP cycle, so the
    // nibble currently indexed by idx always sits in the top four bits.
    assign a_nib  = a_r[WIDTH-1 -: 4];
    assign b_nib  = b_r[WIDTH-1 -: 4];
    assign nib_ne = (a_nib != b_nib);
    assign nib_gt = (a_nib > b_nib);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                if (nib_ne || (idx == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Index, cycle count and result flags. Flags are only written on the
    // terminating CMP cycle, so they hold their last values until the next
    // result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            cycles <= '0;
            aeqb   <= 1'b0;
            agtb   <= 1'b0;
            altb   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx    <= CW'(NIB - 1);
                        cycles <= '0;
                    end
                end
                CMP: begin
                    cycles <= cycles + 1'b1;
                    if (nib_ne) begin
                        aeqb <= 1'b0;
                        agtb <= nib_gt;
                        altb <= ~nib_gt;
                    end else if (idx == '0) begin
                        aeqb <= 1'b1;
                        agtb <= 1'b0;
                        altb <= 1'b0;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Operand storage carries no control meaning, so it is left unreset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a_in ^ sign_mask;
            b_r <= b_in ^ sign_mask;
        end else if (state == CMP) begin
            a_r <= a_r << 4;
            b_r <= b_r << 4;
        end
    end

endmodule

// File: tb/tb_mag_cmp_seq.sv
module tb_mag_cmp_seq;

    localparam int W   = 16;
    localparam int NIB = W / 4;
    localparam int CW  = $clog2(NIB) + 1;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    typedef struct packed {
        logic [2:0]    flags;
        logic [CW-1:0] cyc;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          signed_in = 1'b0;
    logic [W-1:0]  a_in      = '0;
    logic [W-1:0]  b_in      = '0;
    logic          in_ready;
    logic          out_valid;
    logic          aeqb;
    logic          agtb;
    logic          altb;
    logic [CW-1:0] cycles;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mag_cmp_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .signed_in (signed_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aeqb      (aeqb),
        .agtb      (agtb),
        .altb      (altb),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [2:0] f, input int c);
        exp_t e;
        e.flags = f;
        e.cyc   = CW'(c);
        return e;
    endfunction

    // Reference model: count nibbles MSB-first up to and including the first
    // differing one; ordering from a plain signed/unsigned compare.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int   n = 0;
        for (int i = NIB - 1; i >= 0; i--) begin
            n++;
            if (a[4*i +: 4] != b[4*i +: 4]) break;
        end
        e.cyc = CW'(n);
        if (a == b)
            e.flags = EQ;
        else if (s ? ($signed(a) > $signed(b)) : (a > b))
            e.flags = GT;
        else
            e.flags = LT;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready in_ready=%b expected 1", in_ready);
        end
        a_in      = a;
        b_in      = b;
        signed_in = s;
        in_valid  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        a_in      = W'($urandom);
        b_in      = W'($urandom);
        signed_in = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, aeqb, agtb, altb, cycles} !== {2'b10, 3'b000, CW'(0)}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b flags=%b%b%b cyc=%0d expected rdy=1 vld=0 flags=000 cyc=0",
                     in_ready, out_valid, aeqb, agtb, altb, cycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5] = '{16'h1234, 16'h8000, 16'h8000, 16'h12A4, 16'hFFFF};
        logic [W-1:0] tb[5] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h12B4, 16'hFFFE};
        logic         ts[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]   tf[5] = '{EQ, GT, LT, LT, GT};
        int           tc[5] = '{4, 1, 1, 3, 4};
        int           lat;
        exp_t         e;
        for (int k = 0; k < 5; k++) begin
            send(ta[k], tb[k], ts[k], mk(tf[k], tc[k]));
            wait_result(lat);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed%0d_valid out_valid=%b expected 1", k, out_valid);
            end
            checks++;
            if ({aeqb, agtb, altb} !== e.flags) begin
                errors++;
                $display("FAIL directed%0d_flags got %b%b%b expected %b", k, aeqb, agtb, altb, e.flags);
            end
            checks++;
            if (cycles !== e.cyc) begin
                errors++;
                $display("FAIL directed%0d_cycles got %0d expected %0d", k, cycles, e.cyc);
            end
            checks++;
            if (lat !== int'(e.cyc)) begin
                errors++;
                $display("FAIL directed%0d_latency got %0d expected %0d", k, lat, e.cyc);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        send(16'h00F0, 16'h0010, 1'b0, mk(GT, 3));
        wait_result(lat);
        e = sb.pop_front();
        checks++;
        if ({out_valid, aeqb, agtb, altb, cycles} !== {1'b1, e.flags, e.cyc}) begin
            errors++;
            $display("FAIL bp_result got vld=%b flags=%b%b%b cyc=%0d expected vld=1 flags=%b cyc=%0d",
                     out_valid, aeqb, agtb, altb, cycles, e.flags, e.cyc);
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, aeqb, agtb, altb, cycles} !== {2'b10, e.flags, e.cyc}) begin
                errors++;
                $display("FAIL bp_hold%0d got vld=%b rdy=%b flags=%b%b%b cyc=%0d expected vld=1 rdy=0 flags=%b cyc=%0d",
                         k, out_valid, in_ready, aeqb, agtb, altb, cycles, e.flags, e.cyc);
            end
        end
        in_valid = 1'b0;
        release_result();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        checks++;
        if ({aeqb, agtb, altb, cycles} !== {e.flags, e.cyc}) begin
            errors++;
            $display("FAIL bp_flags_kept got flags=%b%b%b cyc=%0d expected flags=%b cyc=%0d",
                     aeqb, agtb, altb, cycles, e.flags, e.cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_ignored_input got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        exp_t e;
        send(16'h0001, 16'h0002, 1'b0, mk(LT, 4));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++;
        if ({in_ready, out_valid, aeqb, agtb, altb, cycles} !== {2'b10, 3'b000, CW'(0)}) begin
            errors++;
            $display("FAIL midreset_async got rdy=%b vld=%b flags=%b%b%b cyc=%0d expected rdy=1 vld=0 flags=000 cyc=0",
                     in_ready, out_valid, aeqb, agtb, altb, cycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_idle got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        send(16'h0001, 16'h0002, 1'b0, mk(LT, 4));
        wait_result(lat);
        e = sb.pop_front();
        checks++;
        if ({out_valid, aeqb, agtb, altb, cycles} !== {1'b1, e.flags, e.cyc} || lat != 4) begin
            errors++;
            $display("FAIL midreset_fresh got vld=%b flags=%b%b%b cyc=%0d lat=%0d expected vld=1 flags=%b cyc=%0d lat=4",
                     out_valid, aeqb, agtb, altb, cycles, lat, e.flags, e.cyc);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int           lat;
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        for (int k = 0; k < 24; k++) begin
            a = W'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
                2:       b = a ^ (W'(1) << $urandom_range(0, 3));
                default: b = W'($urandom);
            endcase
            send(a, b, s, model(a, b, s));
            wait_result(lat);
            e = sb.pop_front();
            checks++;
            if ({out_valid, aeqb, agtb, altb, cycles} !== {1'b1, e.flags, e.cyc} || lat != int'(e.cyc)) begin
                errors++;
                $display("FAIL b2b%0d a=%h b=%h s=%b got vld=%b flags=%b%b%b cyc=%0d lat=%0d expected vld=1 flags=%b cyc=%0d",
                         k, a, b, s, out_valid, aeqb, agtb, altb, cycles, lat, e.flags, e.cyc);
            end
            release_result();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
